// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch buffer.
// One queue entry holds an instruction word together with its fetch address.
package fetch_pkg;

  localparam int          DEFAULT_DEPTH    = 4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer_if.sv
// Bundle of the fetch buffer's redirect, instruction-memory and consumer signals.
// The master modport is the fetch buffer side; slave is the surrounding core.
interface fetch_buffer_if #(
  parameter int DEPTH = fetch_pkg::DEFAULT_DEPTH
);
  localparam int CW = $clog2(DEPTH + 1);

  logic          redirect;
  logic [31:0]   redirect_pc;
  logic [5:0]    imem_addr;
  logic [31:0]   imem_rd;
  logic          instr_valid;
  logic [31:0]   instr;
  logic [31:0]   instr_pc;
  logic          instr_ready;
  logic [CW-1:0] count;

  modport master (
    input  redirect, redirect_pc, imem_rd, instr_ready,
    output imem_addr, instr_valid, instr, instr_pc, count
  );

  modport slave (
    output redirect, redirect_pc, imem_rd, instr_ready,
    input  imem_addr, instr_valid, instr, instr_pc, count
  );
endinterface

// File: rtl/fetch_fifo.sv
// Ring buffer of fetch entries: storage, read/write pointers and occupancy.
// Flush empties the ring and wins over push/pop; storage itself is never reset.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  fetch_entry_t  din,
  output fetch_entry_t  dout,
  output logic [CW-1:0] count
);

  fetch_entry_t  mem [DEPTH];
  logic [PW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [CW-1:0] count_reg, count_next;

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (flush) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
      count_next  = '0;
    end else begin
      if (push) wr_ptr_next = wr_ptr_reg + PW'(1);
      if (pop)  rd_ptr_next = rd_ptr_reg + PW'(1);
      case ({push, pop})
        2'b10:   count_next = count_reg + CW'(1);
        2'b01:   count_next = count_reg - CW'(1);
        default: count_next = count_reg;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
    end
  end

  // Queue is tiny and the head must be visible the cycle after a push, so read is asynchronous.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr_reg] <= din;
  end

  assign dout  = mem[rd_ptr_reg];
  assign count = count_reg;

endmodule

// File: rtl/fetch_buffer.sv
// Instruction fetch buffer: streams sequential words from instruction memory into a
// small queue and presents the head to the consumer; redirect flushes and restarts fetch.
module fetch_buffer
  import fetch_pkg::*;
#(
  parameter int          DEPTH    = DEFAULT_DEPTH,
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic           clk,
  input  logic           reset,
  fetch_buffer_if.master bus
);
  localparam int CW = $clog2(DEPTH + 1);

  logic [31:0]   fetch_pc_reg, fetch_pc_next;
  logic          push, pop, head_valid;
  logic [CW-1:0] count;
  fetch_entry_t  tail_entry, head_entry;

  // A redirect cycle hides the head so the consumer cannot take a stale instruction.
  assign head_valid = (count != '0) && !bus.redirect;
  assign pop        = head_valid && bus.instr_ready;
  assign push       = !bus.redirect && ((count < CW'(DEPTH)) || pop);

  assign tail_entry.pc    = fetch_pc_reg;
  assign tail_entry.instr = bus.imem_rd;

  always_comb begin
    fetch_pc_next = fetch_pc_reg;
    if (bus.redirect)
      fetch_pc_next = bus.redirect_pc & ~32'h3;
    else if (push)
      fetch_pc_next = fetch_pc_reg + 32'd4;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) fetch_pc_reg <= RESET_PC;
    else       fetch_pc_reg <= fetch_pc_next;
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (bus.redirect),
    .din   (tail_entry),
    .dout  (head_entry),
    .count (count)
  );

  assign bus.imem_addr   = fetch_pc_reg[7:2];
  assign bus.instr_valid = head_valid;
  assign bus.instr       = head_valid ? head_entry.instr : 32'h0;
  assign bus.instr_pc    = head_valid ? head_entry.pc    : 32'h0;
  assign bus.count       = count;

endmodule

// File: tb/tb_fetch_buffer.sv
// Directed bench for fetch_buffer with an imem model returning A0000000 + word index.
// Outputs are sampled 1 time unit after the rising edge.
module tb_fetch_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        instr_ready;
  int          total = 0;
  int          bad   = 0;

  always #5 clk = ~clk;

  fetch_buffer_if #(.DEPTH(4)) bus ();

  assign bus.redirect    = redirect;
  assign bus.redirect_pc = redirect_pc;
  assign bus.instr_ready = instr_ready;
  assign bus.imem_rd     = 32'hA000_0000 + {26'd0, bus.imem_addr};

  fetch_buffer #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
    $display("check %s observed=%h", tag, obs);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic head(input string tag, input logic [31:0] pc);
    chk({tag, "_valid"}, 32'(bus.instr_valid), 32'd1);
    chk({tag, "_pc"}, bus.instr_pc, pc);
    chk({tag, "_instr"}, bus.instr, 32'hA000_0000 + {26'd0, pc[7:2]});
  endtask

  task automatic restart(input logic rdy);
    reset = 1'b1;
    instr_ready = rdy;
    tick(1);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    redirect = 1'b0;
    redirect_pc = 32'h0;
    instr_ready = 1'b0;
    tick(2);

    // reset state
    chk("rst_count", 32'(bus.count), 32'd0);
    chk("rst_valid", 32'(bus.instr_valid), 32'd0);
    chk("rst_instr", bus.instr, 32'h0);
    chk("rst_pc", bus.instr_pc, 32'h0);
    chk("rst_imem_addr", 32'(bus.imem_addr), 32'd0);

    // streaming with ready held high, empty before the first push
    instr_ready = 1'b1;
    reset = 1'b0;
    #1;
    chk("empty_ready_valid", 32'(bus.instr_valid), 32'd0);
    for (int k = 0; k < 6; k++) begin
      tick(1);
      head($sformatf("stream%0d", k), 32'(4 * k));
      chk($sformatf("stream%0d_count", k), 32'(bus.count), 32'd1);
    end

    // fill with ready low, then drain while full
    restart(1'b0);
    tick(10);
    chk("full_count", 32'(bus.count), 32'd4);
    chk("full_imem_addr", 32'(bus.imem_addr), 32'd4);
    head("full_head", 32'h0);
    instr_ready = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick(1);
      head($sformatf("drain%0d", k), 32'(4 * k));
      chk($sformatf("drain%0d_count", k), 32'(bus.count), 32'd4);
    end

    // redirect with 3 entries queued, held for two cycles
    restart(1'b0);
    tick(3);
    chk("pre_redir_count", 32'(bus.count), 32'd3);
    instr_ready = 1'b1;
    redirect = 1'b1;
    redirect_pc = 32'h0000_0080;
    #1;
    chk("redir_valid", 32'(bus.instr_valid), 32'd0);
    chk("redir_pc_out", bus.instr_pc, 32'h0);
    tick(1);
    chk("redir1_count", 32'(bus.count), 32'd0);
    chk("redir1_imem_addr", 32'(bus.imem_addr), 32'h20);
    redirect_pc = 32'h0000_0043;
    tick(1);
    chk("redir2_count", 32'(bus.count), 32'd0);
    chk("redir2_imem_addr", 32'(bus.imem_addr), 32'h10);
    redirect = 1'b0;
    #1;
    chk("redir_n1_valid", 32'(bus.instr_valid), 32'd0);
    tick(1);
    head("redir_target", 32'h0000_0040);

    // wrap of the 6-bit word address past 0xFC
    redirect = 1'b1;
    redirect_pc = 32'h0000_00F8;
    tick(1);
    redirect = 1'b0;
    tick(1);
    head("wrap_f8", 32'h0000_00F8);
    tick(1);
    head("wrap_fc", 32'h0000_00FC);
    chk("wrap_imem_addr", 32'(bus.imem_addr), 32'd0);
    tick(1);
    head("wrap_100", 32'h0000_0100);

    // asynchronous reset in mid-cycle with 3 entries queued
    restart(1'b0);
    tick(3);
    chk("pre_areset_count", 32'(bus.count), 32'd3);
    #2;
    reset = 1'b1;
    #1;
    chk("areset_valid", 32'(bus.instr_valid), 32'd0);
    chk("areset_count", 32'(bus.count), 32'd0);
    chk("areset_imem_addr", 32'(bus.imem_addr), 32'd0);
    tick(1);
    reset = 1'b0;
    instr_ready = 1'b1;
    tick(1);
    head("areset_restart", 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_buffer.md
FETCH_BUFFER -- requirements
Module: fetch_buffer

Interface
REQ-001 Parameter DEPTH, default 4: instruction queue entries, power of two, 2..16.
REQ-002 Parameter RESET_PC, default 32'h0000_0000: first fetch byte address after reset.
REQ-003 clk  input  1: single clock; all state updates on posedge clk.
REQ-004 reset  input  1: asynchronous, active-high reset.
REQ-005 redirect  input  1: flush the queue and restart fetch at redirect_pc.
REQ-006 redirect_pc  input  32: new fetch byte address; bits [1:0] ignored and treated as 0.
REQ-007 imem_addr  output  6: word address to the instruction memory, equal to fetch_pc[7:2].
REQ-008 imem_rd  input  32: combinational instruction-memory read data for imem_addr.
REQ-009 instr_valid  output  1: the head entry is presented.
REQ-010 instr  output  32: head instruction word.
REQ-011 instr_pc  output  32: byte address of the head instruction.
REQ-012 instr_ready  input  1: consumer accepts the head this cycle.
REQ-013 count  output  $clog2(DEPTH+1): current occupancy.

Function
REQ-014 fetch_pc is a 32-bit register; imem_addr shall be fetch_pc[7:2] combinationally.
REQ-015 pop = instr_valid & instr_ready; push = !redirect & (count < DEPTH | pop).
REQ-016 On push, entry {fetch_pc, imem_rd} shall be written at the tail and fetch_pc shall advance by 4 (32-bit wrap; imem_addr wraps 63->0).
REQ-017 On pop, the head shall advance; a simultaneous push and pop when full leaves count = DEPTH.
REQ-018 instr_valid = (count != 0) & !redirect; instr/instr_pc = head entry when valid, else 32'h0.
REQ-019 No bypass: a pushed entry becomes visible at the head no earlier than the next cycle.
REQ-020 Redirect has priority over push and pop: the queue is emptied (count <= 0, pointers reset), fetch_pc <= {redirect_pc[31:2],2'b00}, and any head presented is not consumed.
REQ-021 Redirect at cycle N: push of the target at N+1; instr_valid=1 with instr_pc=target at N+2 (redirect low at N+1).
REQ-022 Redirect held multiple cycles: the queue stays empty and fetch_pc tracks redirect_pc each cycle.
REQ-023 Empty with instr_ready=1: no pop and no state change except push.
REQ-024 Full with instr_ready=0: fetch_pc and imem_addr shall hold; the queue contents shall hold.
REQ-025 Steady state with instr_ready held at 1: one instruction is delivered per cycle, in ascending PC order.

Reset
REQ-026 While reset=1: fetch_pc = RESET_PC, count = 0, pointers = 0, instr_valid = 0, instr = 0, instr_pc = 0, imem_addr = RESET_PC[7:2].
REQ-027 Reset asserted mid-operation shall discard all entries immediately, asynchronously to clk.
REQ-028 First push on the first posedge after reset deasserts; first instr_valid one cycle later.

Structure
REQ-029 Package fetch_pkg shall hold the fetch_entry_t struct {pc[31:0], instr[31:0]} and the default DEPTH and RESET_PC constants.
REQ-030 The ring storage, pointers and count shall live in one sub-module, fetch_fifo (push, pop, flush, entry in/out, count).
REQ-031 fetch_fifo storage need not be reset; only pointers and count are reset.

Verification (imem preloaded RAM[i] = 32'hA000_0000 + i)
REQ-032 Reset release, instr_ready=1 -> from cycle 2 onward instr_pc = 0,4,8,... and instr = A0000000, A0000001, ... one per cycle.
REQ-033 instr_ready=0 for 10 cycles after reset -> count saturates at 4, imem_addr holds at 4, and the outputs show instr_pc=0; ready=1 then drains PCs 0,4,8,12,16 in order.
REQ-034 Redirect to 32'h0000_0043 with 3 entries queued -> instr_valid=0 that cycle; count=0; two cycles later instr_pc=0x40 and instr=A0000010.
REQ-035 Fetch to the last word: fetch_pc=0xFC -> the next entry has instr_pc=0x100, imem_addr=0, and instr=A0000000.
REQ-036 Reset asserted mid-stream with count=3 -> instr_valid=0 and count=0 immediately, before the next clk edge; restart at RESET_PC.
REQ-037 Full queue with instr_ready=1 for 5 cycles -> count stays 4 and one instruction is delivered per cycle with no PC gap.
